// File: rtl/mult_pkg.sv
// Shared types and default sizing for the sequential digit-serial multiplier.
package mult_pkg;

  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_DIGIT_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that indexes n digits (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_digit_accum.sv
// One radix-2^DIGIT_BITS step: adds multiplicand * digit, aligned to its digit position.
module mult_digit_accum
  import mult_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DIGIT_BITS = DEFAULT_DIGIT_BITS,
  parameter int IDX_W      = 3
) (
  input  logic [2*WIDTH-1:0]    acc,
  input  logic [WIDTH-1:0]      multiplicand,
  input  logic [DIGIT_BITS-1:0] digit,
  input  logic [IDX_W-1:0]      digit_idx,
  output logic [2*WIDTH-1:0]    acc_next
);

  localparam int SHIFT_W = $clog2(2 * WIDTH) + 1;

  logic [2*WIDTH-1:0] partial;
  logic [SHIFT_W-1:0] shift_amt;

  // The partial product never exceeds WIDTH+DIGIT_BITS bits and the largest
  // shift is WIDTH-DIGIT_BITS, so the aligned term always fits in 2*WIDTH.
  always_comb begin
    partial   = {{WIDTH{1'b0}}, multiplicand} *
                {{(2*WIDTH-DIGIT_BITS){1'b0}}, digit};
    shift_amt = SHIFT_W'(digit_idx) * SHIFT_W'(DIGIT_BITS);
    acc_next  = acc + (partial << shift_amt);
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential multiplier retiring DIGIT_BITS multiplier bits per cycle, valid/ready on both sides.
// Optional signed support is enabled by defining SEQ_MULT_SIGNED_EN.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DIGIT_BITS = DEFAULT_DIGIT_BITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  generate
    if (DIGIT_BITS < 1 || (WIDTH % DIGIT_BITS) != 0) begin : g_bad_params
      $error("seq_multiplier: WIDTH must be a positive multiple of DIGIT_BITS");
    end
  endgenerate

  localparam int N     = WIDTH / DIGIT_BITS;
  localparam int IDX_W = idx_width(N);

`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  state_t             state;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [IDX_W-1:0]   digit_cnt;
  logic               negate_q;
  logic [2*WIDTH-1:0] product_q;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               negate_in;
  logic [2*WIDTH-1:0] acc_next;
  logic               last_digit;

  // Signed operands are reduced to magnitudes so the datapath stays unsigned;
  // the most negative value maps to 2^(WIDTH-1), which is still exact.
  always_comb begin
    signed_op = SIGNED_EN && is_signed;
    a_mag     = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag     = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
    negate_in = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  assign last_digit = (digit_cnt == IDX_W'(N - 1));

  mult_digit_accum #(
    .WIDTH      (WIDTH),
    .DIGIT_BITS (DIGIT_BITS),
    .IDX_W      (IDX_W)
  ) u_digit_accum (
    .acc          (acc_q),
    .multiplicand (mcand_q),
    .digit        (mplier_q[DIGIT_BITS-1:0]),
    .digit_idx    (digit_cnt),
    .acc_next     (acc_next)
  );

  // Control and datapath share one block; product only moves on entry to DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      digit_cnt <= '0;
      negate_q  <= 1'b0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand_q   <= a_mag;
            mplier_q  <= b_mag;
            negate_q  <= negate_in;
            acc_q     <= '0;
            digit_cnt <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          acc_q     <= acc_next;
          mplier_q  <= mplier_q >> DIGIT_BITS;
          digit_cnt <= digit_cnt + 1'b1;
          if (last_digit) begin
            product_q <= negate_q ? (~acc_next + 1'b1) : acc_next;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=32, DIGIT_BITS=4.
// Signed expectations follow SEQ_MULT_SIGNED_EN.
module tb_seq_multiplier;

  localparam int WIDTH = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              is_signed;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       product;
  logic              busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int lat;

  seq_multiplier #(
    .WIDTH      (WIDTH),
    .DIGIT_BITS (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Handshake happens on the posedge after this negedge; returns in cycle 1.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic sv);
    @(negedge clock);
    a = av; b = bv; is_signed = sv; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Called in cycle 1; leaves at the first negedge with out_valid high (or timeout).
  task automatic waitDone(output int cycles);
    cycles = 1;
    while (!out_valid && cycles < 40) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic popOutput(input string tag);
    out_ready = 1'b1;
    checkOutput({tag, "_ready_in_done"}, in_ready, 1'b0);
    @(negedge clock);
    out_ready = 1'b0;
    checkOutput({tag, "_valid_after_pop"}, out_valid, 1'b0);
    checkOutput({tag, "_ready_after_pop"}, in_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b0;
    #1;
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_product", product, 64'h0);
    @(negedge clock);
    reset = 1'b0;

    // Basic unsigned op with latency and BUSY-phase behaviour
    applyStimulus(32'h16, 32'h9, 1'b0);
    checkOutput("t1_busy_c1", busy, 1'b1);
    checkOutput("t1_in_ready_c1", in_ready, 1'b0);
    checkOutput("t1_product_held_c1", product, 64'h0);
    waitDone(lat);
    checkOutput("t1_latency", lat, 9);
    checkOutput("t1_product", product, 64'h0000_0000_0000_00C6);
    popOutput("t1");

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput("t2_product_held_c1", product, 64'h0000_0000_0000_00C6);
    waitDone(lat);
    checkOutput("t2_latency", lat, 9);
    checkOutput("t2_product", product, 64'hFFFF_FFFE_0000_0001);
    popOutput("t2");

    applyStimulus(32'hFFFF_FFFD, 32'h5, 1'b1);
    waitDone(lat);
    checkOutput("t3_latency", lat, 9);
`ifdef SEQ_MULT_SIGNED_EN
    checkOutput("t3_product", product, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    checkOutput("t3_product", product, 64'h0000_0004_FFFF_FFF1);
`endif
    popOutput("t3");

    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1);
    waitDone(lat);
    checkOutput("t4_product", product, 64'h4000_0000_0000_0000);
    popOutput("t4");

    // Consumer stall in DONE with a competing request that must be ignored
    applyStimulus(32'h10, 32'h20, 1'b0);
    waitDone(lat);
    checkOutput("t5_latency", lat, 9);
    a = 32'h7; b = 32'h3; is_signed = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput($sformatf("t5_stall%0d_valid", i), out_valid, 1'b1);
      checkOutput($sformatf("t5_stall%0d_product", i), product, 64'h200);
      checkOutput($sformatf("t5_stall%0d_in_ready", i), in_ready, 1'b0);
    end
    in_valid = 1'b0;
    popOutput("t5");
    @(negedge clock);
    checkOutput("t5_no_accept_busy", busy, 1'b0);
    checkOutput("t5_no_accept_product", product, 64'h200);

    // Reset during BUSY cycle 4 abandons the operation
    applyStimulus(32'h55, 32'h66, 1'b0);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    checkOutput("t6_busy_c4", busy, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_out_valid", out_valid, 1'b0);
    checkOutput("t6_rst_product", product, 64'h0);
    checkOutput("t6_rst_in_ready", in_ready, 1'b1);
    checkOutput("t6_rst_busy", busy, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput($sformatf("t6_idle%0d_out_valid", i), out_valid, 1'b0);
    end

    applyStimulus(32'h3, 32'h4, 1'b0);
    waitDone(lat);
    checkOutput("t7_latency", lat, 9);
    checkOutput("t7_product", product, 64'hC);
    popOutput("t7");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
